// File: rtl/rx_timestamp_insert_pkg.sv
// Shared constants for the RX timestamp insertion stage.
package rx_timestamp_insert_pkg;

  // Module-header ctrl value of the IOQ stage (mirrors the NF2 defines).
  localparam logic [7:0] IO_QUEUE_STAGE_NUM = 8'hff;

  // Timestamp width carried through the FIFO and into the stamp word.
  localparam int TS_W = 32;

  // Output FSM encoding.
  localparam logic [1:0] ST_HDR    = 2'd0;
  localparam logic [1:0] ST_INSERT = 2'd1;
  localparam logic [1:0] ST_BODY   = 2'd2;

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fall-through FIFO: the head entry is visible on dout
// whenever the FIFO is non-empty, without a read request.
module fallthrough_small_fifo #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 2
) (
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             nearly_full,
  output logic             empty,
  input  logic             reset,
  input  logic             clk
);

  localparam logic [MAX_DEPTH_BITS:0] DEPTH   = (MAX_DEPTH_BITS+1)'(1 << MAX_DEPTH_BITS);
  localparam logic [MAX_DEPTH_BITS:0] NF_LVL  = DEPTH - 1'b1;

  logic [WIDTH-1:0]          mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr, rd_ptr;
  logic [MAX_DEPTH_BITS:0]   depth;
  logic                      rd_ok;

  assign rd_ok       = rd_en && !empty;
  assign dout        = mem[rd_ptr];
  assign empty       = (depth == '0);
  assign full        = (depth == DEPTH);
  assign nearly_full = (depth >= NF_LVL);

  // Storage array; contents need no reset since depth gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      depth  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_ok})
        2'b10:   depth <= depth + 1'b1;
        2'b01:   depth <= depth - 1'b1;
        default: depth <= depth;
      endcase
    end
  end

endmodule

// File: rtl/rx_timestamp_insert.sv
// Stamps each packet with its arrival time: after the IOQ module header a
// 64-bit word {32'h0, ts} is inserted, ts being the free-running counter
// value seen when the header was written into this block.
module rx_timestamp_insert
  import rx_timestamp_insert_pkg::*;
#(
  parameter int          DATA_WIDTH = 64,
  parameter int          CTRL_WIDTH = DATA_WIDTH/8,
  parameter int          TS_DIV     = 1,
  parameter logic [31:0] TS_INIT    = 32'h0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  output logic [31:0]           ts_now,
  output logic                  hdr_err
);

  localparam int             FW      = CTRL_WIDTH + DATA_WIDTH + TS_W;
  localparam int             PS_W    = 8;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TS_DIV - 1);

  logic [FW-1:0]         fifo_din, fifo_dout;
  logic                  fifo_wr, fifo_rd, fifo_empty, fifo_nf, fifo_full, fifo_rst;
  logic [CTRL_WIDTH-1:0] head_ctrl;
  logic [DATA_WIDTH-1:0] head_data;
  logic [TS_W-1:0]       head_ts;
  logic                  head_is_hdr;

  logic [PS_W-1:0] ps_cnt;
  logic [TS_W-1:0] ts_cnt, ts_hold;
  logic [1:0]      state, state_nxt;
  logic            ld_ts;

  // Every entry carries the counter value of its write cycle; only the
  // header's copy is ever used.
  assign fifo_din  = {in_ctrl, in_data, ts_cnt};
  assign fifo_wr   = in_wr && !fifo_full;
  assign fifo_rst  = ~reset;
  assign head_ctrl = fifo_dout[FW-1 -: CTRL_WIDTH];
  assign head_data = fifo_dout[TS_W +: DATA_WIDTH];
  assign head_ts   = fifo_dout[TS_W-1:0];
  assign head_is_hdr = (head_ctrl == CTRL_WIDTH'(IO_QUEUE_STAGE_NUM));

  // Headroom of one slot lets the inserted word's bubble be absorbed.
  assign in_rdy = ~fifo_nf;
  assign ts_now = ts_cnt;

  fallthrough_small_fifo #(
    .WIDTH          (FW),
    .MAX_DEPTH_BITS (2)
  ) u_fifo (
    .din         (fifo_din),
    .wr_en       (fifo_wr),
    .rd_en       (fifo_rd),
    .dout        (fifo_dout),
    .full        (fifo_full),
    .nearly_full (fifo_nf),
    .empty       (fifo_empty),
    .reset       (fifo_rst),
    .clk         (clk)
  );

  // Prescaled free-running timestamp; wraps silently at 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps_cnt <= '0;
      ts_cnt <= TS_INIT;
    end else if (ps_cnt == PS_LAST) begin
      ps_cnt <= '0;
      ts_cnt <= ts_cnt + 32'd1;
    end else begin
      ps_cnt <= ps_cnt + 1'b1;
    end
  end

  // Output FSM: forward header, emit stamp word, forward body to EOP.
  always_comb begin
    state_nxt = state;
    fifo_rd   = 1'b0;
    out_wr    = 1'b0;
    out_data  = head_data;
    out_ctrl  = head_ctrl;
    hdr_err   = 1'b0;
    ld_ts     = 1'b0;
    case (state)
      ST_HDR: begin
        if (!fifo_empty && out_rdy) begin
          out_wr  = 1'b1;
          fifo_rd = 1'b1;
          if (head_is_hdr) begin
            ld_ts     = 1'b1;
            state_nxt = ST_INSERT;
          end else begin
            // Not a module header: pass it through and flag it. A ctrl of
            // zero means we are mid-packet, so follow it to its EOP.
            hdr_err = 1'b1;
            if (head_ctrl == '0) state_nxt = ST_BODY;
          end
        end
      end
      ST_INSERT: begin
        out_ctrl = '0;
        out_data = DATA_WIDTH'(ts_hold);
        if (out_rdy) begin
          out_wr    = 1'b1;
          state_nxt = ST_BODY;
        end
      end
      ST_BODY: begin
        if (!fifo_empty && out_rdy) begin
          out_wr  = 1'b1;
          fifo_rd = 1'b1;
          if (head_ctrl != '0) state_nxt = ST_HDR;
        end
      end
      default: state_nxt = ST_HDR;
    endcase
  end

  // FSM state and the captured header timestamp.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_HDR;
      ts_hold <= '0;
    end else begin
      state <= state_nxt;
      if (ld_ts) ts_hold <= head_ts;
    end
  end

endmodule
